demux_1_8_deser: RTL
====================

// Module: demux_1_8_deser
// PURPOSE
// - Serial-to-parallel receive end of the 8:1 select path. A free-running select counter
//   demultiplexes one serial bit per accepted beat into slot i[sel] of an 8-bit word.
// - Presents the completed word on a registered valid/ready output port.
// - Sits downstream of any mux_8_1-based serializer; bit 0 arrives first by default.
// PARAMETERS
// - W          8   word width; number of beats per word (power of 2, >=2)
// - SEL_W      3   select/counter width, $clog2(W)
// - MSB_FIRST  0   0: first beat -> slot 0; 1: first beat -> slot W-1
// PORTS
// - clk         in   1      rising-edge clock
// - rst         in   1      asynchronous, active-high reset
// - din         in   1      serial data bit
// - din_valid   in   1      din is valid this cycle
// - din_ready   out  1      block accepts din this cycle
// - dout        out  W      assembled word
// - dout_valid  out  1      dout holds a complete word
// - dout_ready  in   1      consumer takes dout this cycle
// - sel         out  SEL_W  slot the next accepted bit is written to (debug/monitor)
// BEHAVIOUR
// - Reset (async, rst=1): cnt=0, collect buffer=0, dout=0, dout_valid=0, state=COLLECT.
//   din_ready is 1 after reset.
// - Accept: din_valid && din_ready at the clock edge. Write din to buf[slot].
//   slot = MSB_FIRST ? W-1-cnt : cnt. Increment cnt modulo W; cnt wraps W-1 -> 0.
// - Output slot free: !dout_valid || dout_ready.
// - States:
//   - COLLECT: din_ready=1. The accept with cnt==W-1 completes the word.
//     If the output slot is free, that edge loads dout with the word (last bit included)
//     and sets dout_valid=1. This is zero added latency. Stay in COLLECT.
//     If the output slot is not free, latch the word in buf and go to HOLD.
//   - HOLD: din_ready=0 and cnt stays 0. On the first edge where dout_ready=1, load
//     dout from buf, keep dout_valid=1, and go to COLLECT.
// - dout_valid falls only on an edge with dout_ready=1 and no new word being loaded.
// - dout and dout_valid are stable while dout_valid && !dout_ready.
// - Simultaneous completion and consume: the new word replaces the old one in the same
//   edge. dout_valid stays 1 and no bubble is inserted.
// - Throughput: one word every W cycles sustained when dout_ready=1.
// - Back-pressure: din stalls for exactly one word of buffering.
// - din_valid=0 gaps: cnt and buf hold their values. Partial words persist indefinitely.
// - Reset mid-word or in HOLD discards the partial word and the held word.
//   dout_valid drops immediately on reset.
// - sel output = slot, combinational from cnt.
// - No X propagation: buf bits not yet written in the current word keep prior values.
//   These are always overwritten before the word is presented.
// STRUCTURE
// - Package demux_pkg holds:
//   - localparam DEMUX_W=8 and DEMUX_SEL_W=$clog2(DEMUX_W)
//   - state encoding COLLECT=1'b0, HOLD=1'b1
// - Sub-module demux_1_n: combinational 1:W one-hot write-enable decoder.
//   Inputs: sel, en. Output: W-bit we.
//   It mirrors mux_8_1 select decoding and is instantiated once for buf writes.
// - Top contains the counter, the 2-state FSM, buf[W-1:0], and the dout/dout_valid registers.
// TESTING
// - Reset then stream 0,1,1,0,1,1,1,0 (LSB first) with dout_ready=1:
//   dout=8'b01110110, dout_valid=1 for 1 cycle, on the edge of the 8th beat.
// - Back-to-back words 8'hA5 then 8'h3C, dout_ready=1: two pulses exactly 8 cycles apart.
//   din_ready stays 1 throughout.
// - Hold dout_ready=0 after 8'hA5; send a second word 8'hFF:
//   - din_ready=0 after the 16th beat; dout stays 8'hA5.
//   - Raise dout_ready: next edge dout=8'hFF; din_ready=1 one cycle later.
// - din_valid gaps (3 idle cycles between beats 3 and 4) of 8'h81:
//   sel freezes at 3 during the gap; final dout=8'h81.
// - Assert rst asynchronously after 5 beats and again while in HOLD:
//   dout_valid=0 and sel=0 immediately. The next 8 beats 8'h5A give dout=8'h5A.
// - MSB_FIRST=1, stream 1,0,0,0,0,0,0,0: dout=8'h80; sel sequence is 7,6,...,0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared sizing and FSM encoding for the 1:W serial-to-parallel receive path.
package demux_pkg;
    localparam int DEMUX_W     = 8;
    localparam int DEMUX_SEL_W = $clog2(DEMUX_W);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;
endpackage

// File: rtl/demux_1_n.sv
// Combinational 1:W one-hot write-enable decoder, select decoding matching mux_8_1.
module demux_1_n
    import demux_pkg::*;
#(
    parameter int W     = DEMUX_W,
    parameter int SEL_W = $clog2(W)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [W-1:0]     we
);

    always_comb begin
        we = '0;
        if (en) we[sel] = 1'b1;
    end

endmodule

// File: rtl/demux_1_8_deser.sv
// Serial-to-parallel deserializer: one accepted bit per beat fills slot sel of a W-bit
// word, presented on a registered valid/ready port with one word of back-pressure buffering.
module demux_1_8_deser
    import demux_pkg::*;
#(
    parameter int W         = DEMUX_W,
    parameter int SEL_W     = $clog2(W),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [SEL_W-1:0] sel
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(W - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] slot;
    logic [W-1:0]     col_buf;
    logic [W-1:0]     word_nxt;
    logic [W-1:0]     we;
    logic             accept;
    logic             word_done;
    logic             out_free;
    logic             load_new;
    logic             load_held;

    assign slot      = MSB_FIRST ? (LAST - cnt) : cnt;
    assign sel       = slot;
    assign din_ready = (state == COLLECT);
    assign accept    = din_valid && din_ready;
    assign word_done = accept && (cnt == LAST);
    assign out_free  = !dout_valid || dout_ready;

    demux_1_n #(
        .W     (W),
        .SEL_W (SEL_W)
    ) u_dec (
        .sel (slot),
        .en  (accept),
        .we  (we)
    );

    // The word including this beat's bit, so the final beat can load dout directly.
    assign word_nxt = (col_buf & ~we) | ({W{din}} & we);

    always_comb begin
        state_nxt = state;
        load_new  = 1'b0;
        load_held = 1'b0;
        case (state)
            COLLECT: begin
                if (word_done) begin
                    if (out_free) load_new  = 1'b1;
                    else          state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (dout_ready) begin
                    load_held = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= COLLECT;
            cnt     <= '0;
            col_buf <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt     <= cnt + 1'b1;
                col_buf <= word_nxt;
            end
        end
    end

    // Output register: a new word replaces a consumed one in the same edge, no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load_new) begin
            dout       <= word_nxt;
            dout_valid <= 1'b1;
        end else if (load_held) begin
            dout       <= col_buf;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
